// File: rtl/line_fetch_engine.sv
// Line fill/writeback engine: optionally copies the victim line out to external
// memory, then burst-fills the new line into the victim's local slot.
module line_fetch_engine #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32,
    localparam int TW = $clog2(list_depth),
    localparam int WW = $clog2(list_width)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    output logic                  fetch_gnt,
    input  logic [1:0]            fetch_cmd,
    input  logic [TW-1:0]         fetch_tag,
    input  logic [addr_width-1:0] fetch_addr,
    input  logic [addr_width-1:0] fetch_addr_pre,
    output logic                  fetch_done,
    output logic                  busy,
    output logic [TW+WW-1:0]      mem_raddr,
    output logic                  mem_ren,
    input  logic                  mem_rready,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  mem_rdata_valid,
    output logic [TW+WW-1:0]      mem_waddr,
    output logic                  mem_wen,
    output logic [data_width-1:0] mem_wdata,
    input  logic                  mem_wready,
    output logic                  ext_wr_valid,
    output logic [addr_width-1:0] ext_wr_addr,
    output logic [data_width-1:0] ext_wr_data,
    input  logic                  ext_wr_ready,
    output logic                  ext_rd_req,
    output logic [addr_width-1:0] ext_rd_addr,
    input  logic                  ext_rd_gnt,
    input  logic [data_width-1:0] ext_rd_data,
    input  logic                  ext_rd_data_valid,
    output logic                  ext_rd_ready
);

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_WAIT,
        WB_WR,
        FILL_REQ,
        FILL_DATA,
        DONE
    } state_t;

    localparam logic [1:0]    CMD_WB    = 2'b10;
    localparam logic [WW-1:0] LAST_WORD = WW'(list_width - 1);

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              cmd_ff;
    logic [TW-1:0]           tag_ff;
    logic [addr_width-1:0]   addr_ff;
    logic [addr_width-1:0]   addr_pre_ff;
    logic [WW-1:0]           cnt;
    logic [data_width-1:0]   wb_data;
    logic                    beat_done;

    assign fetch_gnt = fetch_req && (state == IDLE);
    assign beat_done = ext_rd_data_valid && mem_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every output is decoded from the state, so IDLE without a request drives all zeros.
    always_comb begin
        state_next   = state;
        busy         = (state != IDLE);
        fetch_done   = 1'b0;
        mem_ren      = 1'b0;
        mem_raddr    = '0;
        mem_wen      = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        ext_wr_valid = 1'b0;
        ext_wr_addr  = '0;
        ext_wr_data  = '0;
        ext_rd_req   = 1'b0;
        ext_rd_addr  = '0;
        ext_rd_ready = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_gnt) begin
                    state_next = (fetch_cmd == CMD_WB) ? WB_RD : FILL_REQ;
                end
            end
            WB_RD: begin
                mem_ren   = 1'b1;
                mem_raddr = {tag_ff, cnt};
                if (mem_rready) begin
                    state_next = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (mem_rdata_valid) begin
                    state_next = WB_WR;
                end
            end
            WB_WR: begin
                ext_wr_valid = 1'b1;
                ext_wr_addr  = addr_pre_ff | addr_width'(cnt);
                ext_wr_data  = wb_data;
                // The loop only continues while the latched command still asks for writeback.
                if (ext_wr_ready) begin
                    state_next = (cnt == LAST_WORD || cmd_ff != CMD_WB) ? FILL_REQ : WB_RD;
                end
            end
            FILL_REQ: begin
                ext_rd_req  = 1'b1;
                ext_rd_addr = addr_ff;
                if (ext_rd_gnt) begin
                    state_next = FILL_DATA;
                end
            end
            FILL_DATA: begin
                mem_wen      = ext_rd_data_valid;
                mem_wdata    = ext_rd_data;
                mem_waddr    = {tag_ff, cnt};
                ext_rd_ready = mem_wready;
                if (beat_done && cnt == LAST_WORD) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                fetch_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ff      <= '0;
            tag_ff      <= '0;
            addr_ff     <= '0;
            addr_pre_ff <= '0;
            cnt         <= '0;
            wb_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_gnt) begin
                        cmd_ff      <= fetch_cmd;
                        tag_ff      <= fetch_tag;
                        addr_ff     <= fetch_addr;
                        addr_pre_ff <= fetch_addr_pre;
                        cnt         <= '0;
                    end
                end
                WB_WAIT: begin
                    if (mem_rdata_valid) begin
                        wb_data <= mem_rdata;
                    end
                end
                WB_WR: begin
                    if (ext_wr_ready) begin
                        cnt <= (cnt == LAST_WORD) ? '0 : cnt + 1'b1;
                    end
                end
                FILL_DATA: begin
                    if (beat_done) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fetch_engine.sv
// Self-checking bench for line_fetch_engine: memory/bus slave models plus a
// line-level reference of the local memory and expected external writes.
module tb_line_fetch_engine;

    localparam int AW = 32;
    localparam int LD = 4;
    localparam int DW = 32;
    localparam int LW = 32;
    localparam int TW = $clog2(LD);
    localparam int WW = $clog2(LW);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_req = 1'b0;
    logic            fetch_gnt;
    logic [1:0]      fetch_cmd = '0;
    logic [TW-1:0]   fetch_tag = '0;
    logic [AW-1:0]   fetch_addr = '0;
    logic [AW-1:0]   fetch_addr_pre = '0;
    logic            fetch_done;
    logic            busy;
    logic [TW+WW-1:0] mem_raddr;
    logic            mem_ren;
    logic            mem_rready = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;
    logic            mem_rdata_valid = 1'b0;
    logic [TW+WW-1:0] mem_waddr;
    logic            mem_wen;
    logic [DW-1:0]   mem_wdata;
    logic            mem_wready = 1'b0;
    logic            ext_wr_valid;
    logic [AW-1:0]   ext_wr_addr;
    logic [DW-1:0]   ext_wr_data;
    logic            ext_wr_ready = 1'b0;
    logic            ext_rd_req;
    logic [AW-1:0]   ext_rd_addr;
    logic            ext_rd_gnt = 1'b0;
    logic [DW-1:0]   ext_rd_data = '0;
    logic            ext_rd_data_valid = 1'b0;
    logic            ext_rd_ready;

    line_fetch_engine #(
        .addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_cmd(fetch_cmd),
        .fetch_tag(fetch_tag), .fetch_addr(fetch_addr), .fetch_addr_pre(fetch_addr_pre),
        .fetch_done(fetch_done), .busy(busy),
        .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
        .ext_wr_valid(ext_wr_valid), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .ext_wr_ready(ext_wr_ready),
        .ext_rd_req(ext_rd_req), .ext_rd_addr(ext_rd_addr), .ext_rd_gnt(ext_rd_gnt),
        .ext_rd_data(ext_rd_data), .ext_rd_data_valid(ext_rd_data_valid), .ext_rd_ready(ext_rd_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [DW-1:0] local_mem [0:LD*LW-1];
    logic [DW-1:0] model_mem [0:LD*LW-1];
    logic [DW-1:0] fill_line [0:LW-1];
    wr_t           exp_wr_q[$];
    logic [AW-1:0] exp_rd_addr;
    logic [1:0]    cur_cmd;
    logic [TW-1:0] cur_tag;
    bit            rand_mode = 0;
    bit            rd_pending = 0;
    int            rd_wait = 0;
    logic [DW-1:0] rd_q;
    bit            burst_active = 0;
    int            beat_idx = 0;
    int            wr_count = 0, beat_count = 0, done_count = 0, wr_valid_seen = 0;
    int            grant_cyc = 0, done_cyc = 0;
    bit            wr_hold = 0, rd_hold = 0, ren_hold = 0;
    logic [AW-1:0] hold_wr_addr, hold_rd_addr;
    logic [DW-1:0] hold_wr_data;
    logic [TW+WW-1:0] hold_raddr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic any_output();
        return |{fetch_gnt, fetch_done, busy, mem_raddr, mem_ren, mem_waddr, mem_wen, mem_wdata,
                 ext_wr_valid, ext_wr_addr, ext_wr_data, ext_rd_req, ext_rd_addr, ext_rd_ready};
    endfunction

    task automatic sampleTick();
        @(negedge clk);
        #1;
    endtask

    // Slave side: sees the handshakes that the coming posedge will complete.
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_hold  = 0;
            rd_hold  = 0;
            ren_hold = 0;
        end else begin
            if (wr_hold) begin
                checkOutput("ext_wr_hold_valid", ext_wr_valid, 1);
                checkOutput("ext_wr_hold_addr", ext_wr_addr, hold_wr_addr);
                checkOutput("ext_wr_hold_data", ext_wr_data, hold_wr_data);
            end
            if (rd_hold) begin
                checkOutput("ext_rd_req_hold", ext_rd_req, 1);
                checkOutput("ext_rd_addr_hold", ext_rd_addr, hold_rd_addr);
            end
            if (ren_hold) begin
                checkOutput("mem_ren_hold", mem_ren, 1);
                checkOutput("mem_raddr_hold", mem_raddr, hold_raddr);
            end
            if (ext_wr_valid) wr_valid_seen++;
            if (ext_wr_valid && ext_wr_ready) begin
                checkOutput("ext_wr_expected", 64'(exp_wr_q.size() != 0), 1);
                if (exp_wr_q.size() != 0) begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    checkOutput("ext_wr_addr", ext_wr_addr, w.addr);
                    checkOutput("ext_wr_data", ext_wr_data, w.data);
                end
                wr_count++;
            end
            if (mem_ren && mem_rready) begin
                rd_pending = 1;
                rd_wait    = rand_mode ? int'($urandom_range(1, 4)) : 1;
                rd_q       = local_mem[mem_raddr];
            end
            if (ext_rd_req && ext_rd_gnt) begin
                checkOutput("wb_done_before_fill", exp_wr_q.size(), 0);
                checkOutput("ext_rd_addr", ext_rd_addr, exp_rd_addr);
                burst_active = 1;
                beat_idx     = 0;
            end
            if (mem_wen && mem_wready) local_mem[mem_waddr] = mem_wdata;
            if (ext_rd_data_valid && ext_rd_ready) begin
                checkOutput("beat_in_burst", burst_active, 1);
                beat_count++;
                beat_idx++;
                if (beat_idx >= LW) burst_active = 0;
            end
            if (fetch_done) begin
                done_count++;
                done_cyc = cyc;
            end
            wr_hold      = ext_wr_valid && !ext_wr_ready;
            hold_wr_addr = ext_wr_addr;
            hold_wr_data = ext_wr_data;
            rd_hold      = ext_rd_req && !ext_rd_gnt;
            hold_rd_addr = ext_rd_addr;
            ren_hold     = mem_ren && !mem_rready;
            hold_raddr   = mem_raddr;
        end
    end

    task automatic driveSlaves();
        if (!rst_n) begin
            mem_rready = 0; mem_rdata_valid = 0; mem_rdata = '0; mem_wready = 0;
            ext_wr_ready = 0; ext_rd_gnt = 0; ext_rd_data_valid = 0; ext_rd_data = '0;
            return;
        end
        mem_rready   = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        mem_wready   = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        ext_wr_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        ext_rd_gnt   = rand_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
        if (rd_pending) begin
            rd_wait--;
            if (rd_wait == 0) begin
                mem_rdata_valid = 1;
                mem_rdata       = rd_q;
                rd_pending      = 0;
            end else begin
                mem_rdata_valid = 0;
                mem_rdata       = $urandom;
            end
        end else begin
            mem_rdata_valid = rand_mode && ($urandom_range(0, 3) == 0);
            mem_rdata       = $urandom;
        end
        if (burst_active) begin
            ext_rd_data_valid = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            ext_rd_data       = fill_line[beat_idx];
        end else begin
            ext_rd_data_valid = rand_mode && ($urandom_range(0, 3) == 0);
            ext_rd_data       = $urandom;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            driveSlaves();
        end
    end

    task automatic prepareModel(input logic [1:0] cmd, input logic [TW-1:0] tag,
                                input logic [AW-1:0] addr, input logic [AW-1:0] pre, input bit incr);
        wr_t w;
        cur_cmd     = cmd;
        cur_tag     = tag;
        exp_rd_addr = addr;
        for (int k = 0; k < LW; k++) fill_line[k] = incr ? (32'hA000 + k) : $urandom;
        exp_wr_q.delete();
        if (cmd == 2'b10) begin
            for (int k = 0; k < LW; k++) begin
                w.addr = pre + k;
                w.data = model_mem[int'(tag) * LW + k];
                exp_wr_q.push_back(w);
            end
        end
        wr_count = 0; beat_count = 0; done_count = 0; wr_valid_seen = 0;
    endtask

    task automatic issueRequest(input logic [1:0] cmd, input logic [TW-1:0] tag,
                                input logic [AW-1:0] addr, input logic [AW-1:0] pre, input bit incr);
        int n = 0;
        bit got = 0;
        prepareModel(cmd, tag, addr, pre, incr);
        @(posedge clk);
        #2;
        fetch_req = 1; fetch_cmd = cmd; fetch_tag = tag; fetch_addr = addr; fetch_addr_pre = pre;
        while (!got && n < 100) begin
            sampleTick();
            got = fetch_gnt;
            n++;
        end
        checkOutput("grant", got, 1);
        grant_cyc = cyc;
        @(posedge clk);
        #2;
        fetch_req = 0; fetch_cmd = 2'($urandom); fetch_tag = TW'($urandom);
        fetch_addr = $urandom; fetch_addr_pre = $urandom;
        sampleTick();
        checkOutput("busy_after_grant", busy, 1);
    endtask

    task automatic finishRequest();
        int n = 0;
        while (done_count == 0 && n < 6000) begin
            sampleTick();
            n++;
        end
        checkOutput("done_seen", done_count, 1);
        sampleTick();
        checkOutput("done_single_pulse", done_count, 1);
        checkOutput("idle_after_done", busy, 0);
        checkOutput("ext_write_count", wr_count, (cur_cmd == 2'b10) ? LW : 0);
        checkOutput("ext_writes_left", exp_wr_q.size(), 0);
        checkOutput("beat_count", beat_count, LW);
        if (cur_cmd != 2'b10) checkOutput("no_ext_wr_valid", wr_valid_seen, 0);
        for (int k = 0; k < LW; k++) model_mem[int'(cur_tag) * LW + k] = fill_line[k];
        for (int i = 0; i < LD * LW; i++) checkOutput($sformatf("local[%0d]", i), local_mem[i], model_mem[i]);
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [TW-1:0] tag, input logic [AW-1:0] addr,
                                 input logic [AW-1:0] pre, input bit incr, output int latency);
        issueRequest(cmd, tag, addr, pre, incr);
        finishRequest();
        latency = done_cyc - grant_cyc;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]    c;
        logic [TW-1:0] t;
        logic [AW-1:0] a, p;
        int            lat;
        int            n;
        for (int i = 0; i < LD * LW; i++) begin
            local_mem[i] = $urandom;
            model_mem[i] = local_mem[i];
        end
        for (int k = 0; k < LW; k++) begin
            local_mem[LW + k] = 32'hB000 + k;
            model_mem[LW + k] = 32'hB000 + k;
        end

        sampleTick();
        sampleTick();
        checkOutput("reset_outputs", any_output(), 0);
        checkOutput("reset_busy", busy, 0);
        @(posedge clk);
        #2 rst_n = 1;
        sampleTick();
        checkOutput("idle_outputs", any_output(), 0);

        applyStimulus(2'b01, 2, 32'h40, 32'h0, 1, lat);
        checkOutput("fill_latency", lat, 34);
        applyStimulus(2'b10, 1, 32'h200, 32'h80, 0, lat);
        applyStimulus(2'b11, 0, 32'h1000, 32'h2000, 0, lat);
        applyStimulus(2'b00, 3, 32'h3000, 32'h2040, 0, lat);

        // Second request held high across a whole fill.
        prepareModel(2'b01, 0, 32'h400, 32'h0, 0);
        @(posedge clk);
        #2;
        fetch_req = 1; fetch_cmd = 2'b01; fetch_tag = 0; fetch_addr = 32'h400; fetch_addr_pre = 0;
        sampleTick();
        checkOutput("busy_test_grant", fetch_gnt, 1);
        @(posedge clk);
        #2;
        fetch_cmd = 2'b00; fetch_tag = 3; fetch_addr = 32'h500; fetch_addr_pre = 32'h600;
        n = 0;
        while (done_count == 0 && n < 200) begin
            sampleTick();
            checkOutput("gnt_while_busy", fetch_gnt, 0);
            n++;
        end
        finishRequest();
        checkOutput("gnt_after_done", fetch_gnt, 1);
        prepareModel(2'b00, 3, 32'h500, 32'h600, 0);
        @(posedge clk);
        #2 fetch_req = 0;
        finishRequest();

        issueRequest(2'b10, 1, 32'h700, 32'h80, 0);
        n = 0;
        while (wr_count < 5 && n < 500) begin
            sampleTick();
            n++;
        end
        checkOutput("reached_word5", wr_count, 5);
        @(posedge clk);
        #2 rst_n = 0;
        rd_pending = 0;
        burst_active = 0;
        exp_wr_q.delete();
        sampleTick();
        checkOutput("midrst_outputs", any_output(), 0);
        sampleTick();
        checkOutput("midrst_no_done", done_count, 0);
        @(posedge clk);
        #2 rst_n = 1;
        applyStimulus(2'b10, 1, 32'h700, 32'h80, 0, lat);

        rand_mode = 1;
        for (int r = 0; r < 10; r++) begin
            c = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'($urandom);
            t = TW'($urandom);
            a = $urandom & 32'hFFFF_FFE0;
            p = $urandom & 32'hFFFF_FFE0;
            applyStimulus(c, t, a, p, 0, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_fetch_engine.md
# line_fetch_engine

Line fill/writeback engine directly downstream of the cache read controller's fetch port. It accepts one fetch request at a time carrying the victim tag, the new line index, the old line index and a command. When the command says so, it first writes the victim line from local line memory back to external memory. It then burst-reads the new line from external memory into the victim slot and pulses `fetch_done`.

## Interface
- `addr_width`, 32, word address width
- `list_depth`, 4, lines in local line memory; `TW = $clog2(list_depth)`
- `data_width`, 32, word width
- `list_width`, 32, words per line (power of 2); `WW = $clog2(list_width)`

Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `fetch_req`  in  1  request valid; held until `fetch_gnt`
- `fetch_gnt`  out  1  request accepted
- `fetch_cmd`  in  2  2'b10 = writeback + fill; any other value = fill only
- `fetch_tag`  in  TW  victim slot in local memory
- `fetch_addr`  in  addr_width  new line base, low WW bits zero
- `fetch_addr_pre`  in  addr_width  victim line base, used only for writeback
- `fetch_done`  out  1  one-cycle completion pulse
- `busy`  out  1  high whenever state is not IDLE
- `mem_raddr`  out  TW+WW  local read address {tag, word}
- `mem_ren`  out  1  local read request
- `mem_rready`  in  1  read accepted
- `mem_rdata`  in  data_width  read data
- `mem_rdata_valid`  in  1  read data valid, latency ≥1 after accept
- `mem_waddr`  out  TW+WW  local write address {tag, word}
- `mem_wen`  out  1  local write request
- `mem_wdata`  out  data_width  write data
- `mem_wready`  in  1  write accepted
- `ext_wr_valid`  out  1  external single-word write valid
- `ext_wr_addr`  out  addr_width  `addr_pre_ff | word`
- `ext_wr_data`  out  data_width  write data
- `ext_wr_ready`  in  1  write accepted
- `ext_rd_req`  out  1  burst read request for one full line
- `ext_rd_addr`  out  addr_width  `addr_ff`
- `ext_rd_gnt`  in  1  burst accepted
- `ext_rd_data`  in  data_width  beat data, in order word 0 to word list_width-1
- `ext_rd_data_valid`  in  1  beat valid
- `ext_rd_ready`  out  1  beat accepted; equals `mem_wready` in FILL_DATA, else 0

## Operation
- Request latch:
  - `fetch_gnt = fetch_req && state==IDLE`, combinational.
  - On grant, latch `cmd_ff`, `tag_ff`, `addr_ff`, `addr_pre_ff`.
  - Clear word counter `cnt` (WW bits).
- States:
  - IDLE:
    - on grant with cmd 2'b10 → WB_RD
    - on grant with any other cmd → FILL_REQ
  - WB_RD:
    - `mem_ren=1`, `mem_raddr={tag_ff,cnt}`
    - on `mem_rready` → WB_WAIT
  - WB_WAIT:
    - on `mem_rdata_valid`, capture `mem_rdata` into `wb_data` → WB_WR
  - WB_WR:
    - `ext_wr_valid=1`, data `wb_data`, addr `addr_pre_ff | cnt`
    - on `ext_wr_ready`: if `cnt==list_width-1`, clear `cnt` → FILL_REQ; else `cnt+1` → WB_RD
  - FILL_REQ:
    - `ext_rd_req=1`
    - on `ext_rd_gnt` → FILL_DATA
  - FILL_DATA:
    - `mem_wen = ext_rd_data_valid`, `mem_wdata = ext_rd_data`, `mem_waddr = {tag_ff,cnt}`
    - a beat completes when `ext_rd_data_valid && mem_wready`, then `cnt+1`
    - last beat (`cnt==list_width-1`) → DONE
  - DONE:
    - `fetch_done=1` for one cycle → IDLE
- Counter arithmetic:
  - `cnt` is WW bits and wraps to 0 after list_width-1.
  - The wrap only occurs on the transitions listed above.
- Address rule: address OR is safe because bases are line aligned.
- Ignored inputs:
  - `mem_rdata_valid` outside WB_WAIT
  - `ext_rd_data_valid` outside FILL_DATA
  - `fetch_req` while not IDLE (`fetch_gnt` stays 0)

## Timing
- Reset values:
  - state IDLE; `cnt`, all latched registers and `wb_data` 0
  - every output 0 (all are decoded from state, so they are 0 in IDLE with no request)
- Reset mid-operation: return to IDLE immediately; no `fetch_done`; partial writes are not undone.
- Grant:
  - same cycle as `fetch_req`; busy next cycle
  - a new request can be granted in the cycle after DONE
- Fill-only latency: handshake at cycle 0 with zero-wait slaves:
  - FILL_REQ with `ext_rd_gnt` at cycle 1
  - beats at cycles 2..list_width+1
  - `fetch_done` at cycle list_width+2
- Writeback cost:
  - minimum 3 cycles per word (one each in WB_RD, WB_WAIT, WB_WR, with 1-cycle read latency)
  - one local read outstanding at a time
- Back-pressure:
  - `mem_wready` low stalls beats through `ext_rd_ready`; `cnt` holds
  - `ext_wr_ready` low holds `ext_wr_*` stable
- All valid/req outputs hold stable until accepted.

## Test plan
- Fill only, cmd 2'b01, tag 2, addr 0x40, zero-wait slaves, beat k = 0xA000+k:
  - `fetch_done` at cycle 34
  - local words {2,0..31} = 0xA000..0xA01F
- Writeback + fill, cmd 2'b10, tag 1, addr_pre 0x80, local line 1 = 0xB000+k:
  - 32 ext writes to 0x80..0x9F with 0xB000+k, in order, before `ext_rd_req`
  - then fill, then one `fetch_done`
- Back-pressure:
  - random `ext_wr_ready`, `mem_wready`, `mem_rready` and read latency 1-4
  - data and addresses unchanged; no beat dropped or duplicated
- Request while busy:
  - second `fetch_req` held high during a fill → `fetch_gnt` 0 until the cycle after DONE, then granted
- Reset mid-writeback (asserted at word 5):
  - all outputs 0, no `fetch_done`
  - next request starts at word 0
- cmd 2'b11 and 2'b00:
  - behave as fill only; no `ext_wr_valid` ever asserted
